ecc_secded_codec: RTL and testbench
===================================

ECC_SECDED_CODEC -- requirements
Module: ecc_secded_codec

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 8, which is the width of each error-event counter.
REQ-002 SHALL have port wb_clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port resetb, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the upstream transaction is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a transaction this cycle.
REQ-006 SHALL have port in_mode, input, 1 bit: 0 = encode, 1 = decode; sampled with in_data.
REQ-007 SHALL have port in_data, input, 16 bits: message in bits [7:0] (encode) or codeword in bits [12:0] (decode); unused bits are ignored.
REQ-008 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream stage accepts the result.
REQ-010 SHALL have port out_data, output, 16 bits: codeword (encode) or {8'h00, data} (decode).
REQ-011 SHALL have port out_err, output, 2 bits: 00 none, 01 corrected, 10 uncorrectable; always 00 in encode mode.
REQ-012 SHALL have port clr_cnt, input, 1 bit: synchronous clear of both counters.
REQ-013 SHALL have port corr_cnt, output, CNT_WIDTH bits: count of corrected decodes.
REQ-014 SHALL have port uncorr_cnt, output, CNT_WIDTH bits: count of uncorrectable decodes.

Function
REQ-015 SHALL use this codeword layout: cw[7:0] = d[7:0], cw[11:8] = c[3:0], cw[12] = p, cw[15:13] = 0.
REQ-016 SHALL compute the check bits as: c0 = d0^d1^d3^d4^d6; c1 = d0^d2^d3^d5^d6; c2 = d1^d2^d3^d7; c3 = d4^d5^d6^d7.
REQ-017 SHALL compute p as the XOR of cw[11:0].
REQ-018 SHALL decode using two quantities:
- syndrome s[3:0] = recomputed c XOR received c;
- P = XOR of received cw[12:0].
REQ-019 SHALL map syndromes to data bits as follows: d0..d7 correspond to s = 3, 5, 6, 7, 9, 10, 11, 12; c_i corresponds to s = 1<<i.
REQ-020 SHALL apply these decode rules:
- s=0, P=0: out_err=00.
- P=1 with s in {0, 1, 2, 4, 8}: out_err=01, data unchanged.
- P=1 with s equal to a data syndrome: flip that data bit, out_err=01.
- P=1 with s in {13, 14, 15}: out_err=10.
- s!=0, P=0: out_err=10.
REQ-021 SHALL output the received data bits [7:0] unmodified when out_err=10.
REQ-022 SHALL be a two-stage pipeline:
- stage 1 registers mode, data and syndrome/parity;
- stage 2 registers out_data and out_err.
REQ-023 SHALL define advance = !out_valid | out_ready, and SHALL drive in_ready = advance combinationally.
REQ-024 SHALL accept a transaction when in_valid & in_ready.
REQ-025 SHALL, when advance is 1, move both stages forward together and propagate a bubble when no transaction is accepted.
REQ-026 SHALL, when advance is 0, hold both stages, out_data and out_err stable.
REQ-027 SHALL present the result on out_valid exactly 2 cycles after acceptance when out_ready is held high.
REQ-028 SHALL sustain a throughput of 1 transaction per cycle.
REQ-029 SHALL increment corr_cnt or uncorr_cnt once per decode result, on the cycle that result enters stage 2.
REQ-030 SHALL saturate each counter at all-ones.
REQ-031 SHALL give clr_cnt priority over a same-cycle increment: the counter becomes 0 and the increment is lost.
REQ-032 SHALL carry mode per transaction, so that interleaved encode and decode transactions are handled independently.

Reset
REQ-033 SHALL, while resetb=0, drive asynchronously:
- out_valid = 0, out_data = 0, out_err = 00;
- corr_cnt = 0, uncorr_cnt = 0;
- both stage valid bits = 0.
REQ-034 SHALL discard in-flight transactions when reset is asserted mid-operation, with no output produced for them after release.
REQ-035 SHALL drive in_ready = 1 in the first cycle after resetb deasserts.

Verification
REQ-036 SHALL verify encode: in_mode=0, in_data=0x004B -> out_data=0x0A4B, out_err=00, out_valid 2 cycles after acceptance.
REQ-037 SHALL verify single-bit correction: decode 0x0A43 (d3 flipped) -> out_data=0x004B, out_err=01, corr_cnt=1.
REQ-038 SHALL verify the double-error and parity-bit-error cases:
- decode 0x0A48 -> out_data=0x0048, out_err=10, uncorr_cnt=1;
- decode 0x1A4B -> out_data=0x004B, out_err=01.
REQ-039 SHALL verify backpressure:
- stream 4 transactions with out_ready=0 for 5 cycles -> in_ready=0 after 2 are accepted;
- out_data stays stable while stalled;
- all 4 results appear in order after out_ready=1, with none lost or duplicated.
REQ-040 SHALL verify counter saturation and clear:
- 256 corrected decodes -> corr_cnt=0xFF;
- clr_cnt asserted in the same cycle as an increment -> corr_cnt=0.
REQ-041 SHALL verify reset mid-operation: assert resetb=0 with 2 transactions in flight -> out_valid=0 immediately and no stale output after release.

Source files
------------

// File: rtl/ecc_secded_codec.sv
// SECDED codec for 8-bit messages in a 13-bit codeword (Hamming(12,8) + overall parity).
// Two-stage valid/ready pipeline with a shared stall, one transaction per cycle,
// and saturating counters for corrected and uncorrectable decode results.
module ecc_secded_codec #(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 resetb,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [15:0]          in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          out_data,
    output logic [1:0]           out_err,
    input  logic                 clr_cnt,
    output logic [CNT_WIDTH-1:0] corr_cnt,
    output logic [CNT_WIDTH-1:0] uncorr_cnt
);

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_CORR   = 2'b01,
        ERR_UNCORR = 2'b10
    } err_e;

    // Hamming check bits over the 8 data bits
    function automatic logic [3:0] check_bits(input logic [7:0] d);
        logic [3:0] c;
        c[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        c[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        c[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
        c[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
        return c;
    endfunction

    logic       advance;
    logic       accept;
    logic [3:0] in_chk;
    logic [3:0] in_syn;
    logic       in_par;
    logic       unused_bits;

    // stage 1 registers
    logic       s1_valid;
    logic       s1_mode;
    logic [7:0] s1_data;
    logic [3:0] s1_chk;
    logic       s1_par;

    // stage 2 next-state
    logic [7:0]  flip_mask;
    logic [7:0]  dec_data;
    err_e        dec_err;
    logic [15:0] nxt_data;
    err_e        nxt_err;
    logic        inc_corr;
    logic        inc_uncorr;

    assign advance     = !out_valid | out_ready;
    assign in_ready    = advance;
    assign accept      = in_valid & advance;
    assign unused_bits = ^in_data[15:13];

    // Stage 1 carries either the encode check bits/parity or the decode
    // syndrome/overall parity in the same fields, selected by mode.
    always_comb begin
        in_chk = check_bits(in_data[7:0]);
        in_syn = in_chk ^ in_data[11:8];
        in_par = in_mode ? ^in_data[12:0] : ^{in_chk, in_data[7:0]};
    end

    // Stage 1: capture accepted transaction, or a bubble when none is accepted
    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_data  <= '0;
            s1_chk   <= '0;
            s1_par   <= 1'b0;
        end else if (advance) begin
            s1_valid <= accept;
            if (accept) begin
                s1_mode <= in_mode;
                s1_data <= in_data[7:0];
                s1_chk  <= in_mode ? in_syn : in_chk;
                s1_par  <= in_par;
            end
        end
    end

    // Decode classification and single-bit data correction from syndrome/parity
    always_comb begin
        flip_mask = '0;
        dec_err   = ERR_NONE;
        if (!s1_par) begin
            if (s1_chk != 4'd0)
                dec_err = ERR_UNCORR;
        end else begin
            dec_err = ERR_CORR;
            case (s1_chk)
                4'd3:    flip_mask = 8'h01;
                4'd5:    flip_mask = 8'h02;
                4'd6:    flip_mask = 8'h04;
                4'd7:    flip_mask = 8'h08;
                4'd9:    flip_mask = 8'h10;
                4'd10:   flip_mask = 8'h20;
                4'd11:   flip_mask = 8'h40;
                4'd12:   flip_mask = 8'h80;
                4'd13, 4'd14, 4'd15: dec_err = ERR_UNCORR;
                default: flip_mask = '0;
            endcase
        end
        dec_data = s1_data ^ flip_mask;
        if (s1_mode) begin
            nxt_data = {8'h00, dec_data};
            nxt_err  = dec_err;
        end else begin
            nxt_data = {3'b000, s1_par, s1_chk, s1_data};
            nxt_err  = ERR_NONE;
        end
        inc_corr   = advance & s1_valid & s1_mode & (dec_err == ERR_CORR);
        inc_uncorr = advance & s1_valid & s1_mode & (dec_err == ERR_UNCORR);
    end

    // Stage 2: register the result; hold it while downstream stalls
    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 2'b00;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= nxt_data;
                out_err  <= nxt_err;
            end
        end
    end

    // Saturating event counters; clear wins over a same-cycle increment
    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (clr_cnt) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else begin
            if (inc_corr && corr_cnt != '1)
                corr_cnt <= corr_cnt + 1'b1;
            if (inc_uncorr && uncorr_cnt != '1)
                uncorr_cnt <= uncorr_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ecc_secded_codec.sv
// Scoreboard bench for ecc_secded_codec: a driver pushes expected results
// from a behavioural SECDED model; an independent monitor pops and compares.
module tb_ecc_secded_codec;

    localparam int unsigned CW = 8;

    logic          wb_clk_i = 1'b0;
    logic          resetb = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_mode = 1'b0;
    logic [15:0]   in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [15:0]   out_data;
    logic [1:0]    out_err;
    logic          clr_cnt = 1'b0;
    logic [CW-1:0] corr_cnt;
    logic [CW-1:0] uncorr_cnt;

    ecc_secded_codec #(.CNT_WIDTH(CW)) dut (
        .wb_clk_i  (wb_clk_i),
        .resetb    (resetb),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .clr_cnt   (clr_cnt),
        .corr_cnt  (corr_cnt),
        .uncorr_cnt(uncorr_cnt)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  err;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int unsigned exp_corr = 0;
    int unsigned exp_uncorr = 0;
    bit          rnd_rdy = 1'b0;

    always @(posedge wb_clk_i) cyc <= cyc + 1;

    // Syndrome position of each data bit; check bits sit at powers of two
    function automatic logic [3:0] pos_of(input int i);
        int p[8] = '{3, 5, 6, 7, 9, 10, 11, 12};
        return p[i][3:0];
    endfunction

    function automatic logic [12:0] ref_encode(input logic [7:0] d);
        logic [3:0] c = 4'd0;
        for (int i = 0; i < 8; i++)
            if (d[i]) c ^= pos_of(i);
        return {^{c, d}, c, d};
    endfunction

    function automatic exp_t ref_decode(input logic [12:0] cw);
        exp_t       e;
        logic [7:0] d = cw[7:0];
        logic [12:0] re = ref_encode(d);
        logic [3:0] s = re[11:8] ^ cw[11:8];
        logic       p = ^cw;
        e.data = {8'h00, d};
        e.err  = 2'b00;
        e.cyc  = 0;
        e.lat  = 1'b0;
        if (!p) begin
            if (s != 0) e.err = 2'b10;
        end else if (s == 0 || s == 1 || s == 2 || s == 4 || s == 8) begin
            e.err = 2'b01;
        end else if (s >= 13) begin
            e.err = 2'b10;
        end else begin
            for (int i = 0; i < 8; i++)
                if (pos_of(i) == s) d[i] = ~d[i];
            e.data = {8'h00, d};
            e.err  = 2'b01;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic send(input logic m, input logic [15:0] d, input bit lat);
        int unsigned waited = 0;
        exp_t e;
        @(negedge wb_clk_i);
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge wb_clk_i);
            #1;
            waited++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready stuck 0 for data 0x%0h", d);
            in_valid = 1'b0;
            return;
        end
        if (m) begin
            e = ref_decode(d[12:0]);
            if (e.err == 2'b01 && exp_corr < 255) exp_corr++;
            if (e.err == 2'b10 && exp_uncorr < 255) exp_uncorr++;
        end else begin
            e.data = {3'b000, ref_encode(d[7:0])};
            e.err  = 2'b00;
        end
        e.cyc = cyc;
        e.lat = lat;
        sb.push_back(e);
        @(posedge wb_clk_i);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain_and_check_counts(input string tag);
        int unsigned n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            @(negedge wb_clk_i);
            n++;
        end
        @(negedge wb_clk_i);
        check({tag, "_drain_left"}, sb.size(), 0);
        check({tag, "_corr_cnt"}, corr_cnt, exp_corr);
        check({tag, "_uncorr_cnt"}, uncorr_cnt, exp_uncorr);
    endtask

    // Monitor: pops expected results on every output handshake, checks stall stability
    initial begin
        logic        stall_prev = 1'b0;
        logic [15:0] prev_data = '0;
        logic [1:0]  prev_err = '0;
        exp_t        e;
        forever begin
            @(negedge wb_clk_i);
            #2;
            if (stall_prev && resetb) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", {14'd0, out_err, out_data}, {14'd0, prev_err, prev_data});
            end
            stall_prev = resetb && out_valid && !out_ready;
            prev_data  = out_data;
            prev_err   = out_err;
            if (resetb && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got 0x%0h err %0b, expected none", out_data, out_err);
                end else begin
                    e = sb.pop_front();
                    check("result", {14'd0, out_err, out_data}, {14'd0, e.err, e.data});
                    if (e.lat) check("latency", cyc - e.cyc, 2);
                end
            end
        end
    end

    // Random downstream backpressure
    initial begin
        forever begin
            @(negedge wb_clk_i);
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [15:0] d;
        logic [12:0] cw;
        int unsigned b1, b2;

        // reset state
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 16'h0);
        check("rst_out_err", out_err, 2'b00);
        check("rst_corr", corr_cnt, 0);
        check("rst_uncorr", uncorr_cnt, 0);
        repeat (2) @(negedge wb_clk_i);
        resetb = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1'b1);

        // directed encode / correct / uncorrectable / parity-bit error
        send(1'b0, 16'h004B, 1'b1);
        send(1'b1, 16'h0A43, 1'b1);
        send(1'b1, 16'h0A48, 1'b1);
        send(1'b1, 16'h1A4B, 1'b1);
        send(1'b1, 16'hEA4B, 1'b1);
        drain_and_check_counts("directed");

        // backpressure: two accepted, then in_ready must drop
        out_ready = 1'b0;
        send(1'b0, 16'h00A5, 1'b0);
        send(1'b1, 16'h0A43, 1'b0);
        @(negedge wb_clk_i);
        in_valid = 1'b1;
        in_mode  = 1'b0;
        in_data  = 16'h003C;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", in_ready, 1'b0);
            @(negedge wb_clk_i);
        end
        check("bp_accepted", sb.size(), 2);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(1'b0, 16'h003C, 1'b0);
        send(1'b1, 16'h0A48, 1'b0);
        drain_and_check_counts("backpressure");

        // randomized mix with random backpressure
        rnd_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                send(1'b0, d, 1'b0);
            end else begin
                cw = ref_encode(d[7:0]);
                b1 = $urandom_range(0, 12);
                b2 = (b1 + $urandom_range(1, 12)) % 13;
                case ($urandom_range(0, 3))
                    0: ;
                    1: cw[b1] = ~cw[b1];
                    2: begin cw[b1] = ~cw[b1]; cw[b2] = ~cw[b2]; end
                    default: cw = d[12:0];
                endcase
                send(1'b1, {d[15:13], cw}, 1'b0);
            end
        end
        rnd_rdy = 1'b0;
        @(negedge wb_clk_i);
        out_ready = 1'b1;
        drain_and_check_counts("random");

        // saturation, then clear colliding with an increment
        @(negedge wb_clk_i);
        clr_cnt = 1'b1;
        @(negedge wb_clk_i);
        clr_cnt = 1'b0;
        exp_corr = 0;
        exp_uncorr = 0;
        for (int n = 0; n < 256; n++) send(1'b1, 16'h0A43, 1'b0);
        drain_and_check_counts("saturate");
        check("sat_value", corr_cnt, 8'hFF);
        send(1'b1, 16'h0A43, 1'b0);
        @(negedge wb_clk_i);
        clr_cnt = 1'b1;
        @(negedge wb_clk_i);
        clr_cnt = 1'b0;
        exp_corr = 0;
        exp_uncorr = 0;
        drain_and_check_counts("clear");

        // reset with two transactions in flight
        send(1'b1, 16'h0A43, 1'b0);
        send(1'b0, 16'h0011, 1'b0);
        resetb = 1'b0;
        sb.delete();
        exp_corr = 0;
        exp_uncorr = 0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, 16'h0);
        check("midrst_corr", corr_cnt, 0);
        repeat (2) @(negedge wb_clk_i);
        resetb = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1'b1);
        repeat (6) @(negedge wb_clk_i);
        check("midrst_no_output", out_valid, 1'b0);
        send(1'b0, 16'h004B, 1'b1);
        drain_and_check_counts("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
